// File: rtl/boreal_action_gate_if.sv
// Bundles the MMIO bus, the action-request handshake and the executor handshake of boreal_action_gate.
// Ports: sel/wr/addr/wdata/rdata/ack (MMIO); act_valid/act_* /act_ready (request); exec_* (executor); deny_pulse.
// master = VM / host / executor side, slave = the gate itself.
interface boreal_action_gate_if;
  logic        sel;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  logic        act_valid;
  logic [31:0] act_opcode;
  logic [31:0] act_target;
  logic [31:0] act_arg0;
  logic [31:0] act_arg1;
  logic [31:0] act_context_hash;
  logic [31:0] act_policy_hash;
  logic [31:0] act_bounds;
  logic [31:0] act_nonce;
  logic        act_ready;

  logic        exec_valid;
  logic [31:0] exec_opcode;
  logic [31:0] exec_target;
  logic [31:0] exec_arg0;
  logic [31:0] exec_arg1;
  logic        exec_ready;

  logic        deny_pulse;

  modport master (
    output sel, wr, addr, wdata,
    input  rdata, ack,
    output act_valid, act_opcode, act_target, act_arg0, act_arg1,
    output act_context_hash, act_policy_hash, act_bounds, act_nonce,
    input  act_ready,
    input  exec_valid, exec_opcode, exec_target, exec_arg0, exec_arg1,
    output exec_ready,
    input  deny_pulse
  );

  modport slave (
    input  sel, wr, addr, wdata,
    output rdata, ack,
    input  act_valid, act_opcode, act_target, act_arg0, act_arg1,
    input  act_context_hash, act_policy_hash, act_bounds, act_nonce,
    output act_ready,
    output exec_valid, exec_opcode, exec_target, exec_arg0, exec_arg1,
    input  exec_ready,
    output deny_pulse
  );
endinterface

// File: rtl/boreal_action_gate.sv
// Purpose: captures one Decision VM action request, checks it against MMIO policy in EVAL_CYCLES
//   cycles, forwards approvals to the executor and counts/logs denials (MMIO base 0x1004_0000).
// Ports: clk, rst (sync active-high), bus (boreal_action_gate_if.slave: MMIO + request + executor).
// Optional macro BOREAL_GATE_NONCE_EN adds a strictly-increasing nonce check (reason 5).
module boreal_action_gate #(
  parameter int EVAL_CYCLES = 2,
  parameter int OPC_BITS    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  boreal_action_gate_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EVAL  = 3'd1,
    S_ISSUE = 3'd2,
    S_DENY  = 3'd3,
    S_DROP  = 3'd4
  } state_t;

  localparam int CW = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;

  state_t      state;
  logic [CW-1:0] eval_cnt;

  logic        act_ready_q;
  logic        exec_valid_q;
  logic        deny_q;
  logic [31:0] exec_opcode_q, exec_target_q, exec_arg0_q, exec_arg1_q;

  // latched request
  logic [31:0] req_opcode, req_target, req_arg0, req_arg1;
  logic [31:0] req_ctx, req_pol, req_bounds, req_nonce;

  // live policy registers and the copy taken at capture
  logic        ctrl_en;
  logic [31:0] allow_mask, tgt_lo, tgt_hi, arg0_max;
  logic        snap_en;
  logic [31:0] snap_mask, snap_lo, snap_hi, snap_amax;

  logic [31:0] accept_cnt, deny_cnt;
  logic [2:0]  last_reason;
`ifdef BOREAL_GATE_NONCE_EN
  logic [31:0] last_nonce;
`endif

  logic [7:0]  off;
  logic        wr_en;
  logic        clr_cnt;
  logic [2:0]  reason;
  logic [31:0] rdata_c;

  assign off     = bus.addr[7:0];
  assign wr_en   = bus.sel && bus.wr;
  assign clr_cnt = wr_en && (off == 8'h00) && bus.wdata[1];

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Verdict from the latched request and the policy snapshot; first failure wins.
  always_comb begin
    reason = 3'd0;
    if (!snap_en)
      reason = 3'd1;
    else if (((req_opcode >> OPC_BITS) != 32'd0) || !snap_mask[req_opcode[OPC_BITS-1:0]])
      reason = 3'd2;
    else if ((req_target < snap_lo) || (req_target > snap_hi))
      reason = 3'd3;
    else if (req_arg0 > snap_amax)
      reason = 3'd4;
`ifdef BOREAL_GATE_NONCE_EN
    else if (req_nonce <= last_nonce)
      reason = 3'd5;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      eval_cnt      <= '0;
      act_ready_q   <= 1'b1;
      exec_valid_q  <= 1'b0;
      deny_q        <= 1'b0;
      exec_opcode_q <= '0;
      exec_target_q <= '0;
      exec_arg0_q   <= '0;
      exec_arg1_q   <= '0;
      req_opcode    <= '0;
      req_target    <= '0;
      req_arg0      <= '0;
      req_arg1      <= '0;
      req_ctx       <= '0;
      req_pol       <= '0;
      req_bounds    <= '0;
      req_nonce     <= '0;
      ctrl_en       <= 1'b0;
      allow_mask    <= '0;
      tgt_lo        <= '0;
      tgt_hi        <= 32'hFFFF_FFFF;
      arg0_max      <= 32'hFFFF_FFFF;
      snap_en       <= 1'b0;
      snap_mask     <= '0;
      snap_lo       <= '0;
      snap_hi       <= 32'hFFFF_FFFF;
      snap_amax     <= 32'hFFFF_FFFF;
      accept_cnt    <= '0;
      deny_cnt      <= '0;
      last_reason   <= '0;
`ifdef BOREAL_GATE_NONCE_EN
      last_nonce    <= '0;
`endif
    end else begin
      deny_q <= 1'b0;

      if (wr_en) begin
        case (off)
          8'h00: ctrl_en    <= bus.wdata[0];
          8'h04: allow_mask <= bus.wdata;
          8'h08: tgt_lo     <= bus.wdata;
          8'h0C: tgt_hi     <= bus.wdata;
          8'h10: arg0_max   <= bus.wdata;
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          act_ready_q <= 1'b1;
          if (bus.act_valid) begin
            req_opcode  <= bus.act_opcode;
            req_target  <= bus.act_target;
            req_arg0    <= bus.act_arg0;
            req_arg1    <= bus.act_arg1;
            req_ctx     <= bus.act_context_hash;
            req_pol     <= bus.act_policy_hash;
            req_bounds  <= bus.act_bounds;
            req_nonce   <= bus.act_nonce;
            // Snapshot uses pre-write values, so a same-edge MMIO write only affects the next capture.
            snap_en     <= ctrl_en;
            snap_mask   <= allow_mask;
            snap_lo     <= tgt_lo;
            snap_hi     <= tgt_hi;
            snap_amax   <= arg0_max;
            act_ready_q <= 1'b0;
            eval_cnt    <= '0;
            state       <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (eval_cnt == CW'(EVAL_CYCLES - 1)) begin
            last_reason <= reason;
            if (reason == 3'd0) begin
              exec_valid_q  <= 1'b1;
              exec_opcode_q <= req_opcode;
              exec_target_q <= req_target;
              exec_arg0_q   <= req_arg0;
              exec_arg1_q   <= req_arg1;
`ifdef BOREAL_GATE_NONCE_EN
              last_nonce    <= req_nonce;
`endif
              state         <= S_ISSUE;
            end else begin
              deny_q   <= 1'b1;
              deny_cnt <= sat_inc(deny_cnt);
              state    <= S_DENY;
            end
          end else begin
            eval_cnt <= eval_cnt + CW'(1);
          end
        end
        S_ISSUE: begin
          if (bus.exec_ready) begin
            exec_valid_q <= 1'b0;
            accept_cnt   <= sat_inc(accept_cnt);
            state        <= S_DROP;
          end
        end
        S_DENY: state <= S_DROP;
        S_DROP: begin
          // Wait for the VM to release act_valid so the same request is not captured twice.
          if (!bus.act_valid) begin
            act_ready_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Placed last so a clear overrides any increment on the same edge.
      if (clr_cnt) begin
        accept_cnt <= '0;
        deny_cnt   <= '0;
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    case (off)
      8'h00: rdata_c[0] = ctrl_en;
      8'h04: rdata_c = allow_mask;
      8'h08: rdata_c = tgt_lo;
      8'h0C: rdata_c = tgt_hi;
      8'h10: rdata_c = arg0_max;
      8'h14: rdata_c = accept_cnt;
      8'h18: rdata_c = deny_cnt;
      8'h1C: begin
        rdata_c[2:0]  = state;
        rdata_c[10:8] = last_reason;
        rdata_c[16]   = act_ready_q;
      end
`ifdef BOREAL_GATE_NONCE_EN
      8'h20: rdata_c = last_nonce;
`endif
      default: ;
    endcase
  end

  assign bus.rdata       = rdata_c;
  assign bus.ack         = bus.sel;
  assign bus.act_ready   = act_ready_q;
  assign bus.exec_valid  = exec_valid_q;
  assign bus.exec_opcode = exec_opcode_q;
  assign bus.exec_target = exec_target_q;
  assign bus.exec_arg0   = exec_arg0_q;
  assign bus.exec_arg1   = exec_arg1_q;
  assign bus.deny_pulse  = deny_q;

  // Request fields that policy does not inspect are kept for completeness only.
  logic unused_bits;
  assign unused_bits = ^{bus.addr[31:8], req_ctx, req_pol, req_bounds
`ifndef BOREAL_GATE_NONCE_EN
                         , req_nonce
`endif
                        };

endmodule

// File: tb/tb_boreal_action_gate.sv
module tb_boreal_action_gate;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  boreal_action_gate_if bus();
  boreal_action_gate #(.EVAL_CYCLES(2), .OPC_BITS(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int passes = 0;
  int exp_acc = 0;
  int exp_deny = 0;
  logic [31:0] nonce_seq = 32'd100;

  task automatic mmio_write(input logic [7:0] off, input logic [31:0] d);
    bus.sel = 1'b1; bus.wr = 1'b1; bus.addr = 32'h1004_0000 | {24'd0, off}; bus.wdata = d;
    @(posedge clk);
    @(negedge clk);
    bus.sel = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic mmio_read(input logic [7:0] off, output logic [31:0] d);
    bus.sel = 1'b1; bus.wr = 1'b0; bus.addr = 32'h1004_0000 | {24'd0, off};
    #1;
    d = bus.rdata;
    bus.sel = 1'b0;
  endtask

  task automatic read_reason(output logic [2:0] r);
    logic [31:0] s;
    mmio_read(8'h1C, s);
    r = s[10:8];
  endtask

  task automatic drive_req(input logic [31:0] op, tgt, a0, nonce);
    bus.act_valid = 1'b1; bus.act_opcode = op; bus.act_target = tgt; bus.act_arg0 = a0;
    bus.act_arg1 = 32'h0000_00A1; bus.act_context_hash = 32'hC0FF_EE00;
    bus.act_policy_hash = 32'hBEEF_0001; bus.act_bounds = 32'h0000_FFFF; bus.act_nonce = nonce;
  endtask

  // Called at a negedge with the gate idle; runs 8 cycles after the capture edge.
  task automatic do_req(input logic [31:0] op, tgt, a0, nonce, input int wr_at,
                        input logic [7:0] wr_off, input logic [31:0] wr_d,
                        output int n_deny, output int n_exec, output int first_exec);
    n_deny = 0; n_exec = 0; first_exec = -1;
    bus.exec_ready = 1'b1;
    drive_req(op, tgt, a0, nonce);
    @(posedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.deny_pulse) n_deny++;
      if (bus.exec_valid) begin
        n_exec++;
        if (first_exec < 0) first_exec = i;
      end
      if (i == 1) bus.act_valid = 1'b0;
      if (i == wr_at) begin
        bus.sel = 1'b1; bus.wr = 1'b1; bus.addr = 32'h1004_0000 | {24'd0, wr_off}; bus.wdata = wr_d;
      end else if (i == wr_at + 1) begin
        bus.sel = 1'b0; bus.wr = 1'b0;
      end
    end
    bus.exec_ready = 1'b0;
  endtask

  task automatic setup_policy();
    mmio_write(8'h00, 32'd1);
    mmio_write(8'h04, 32'h4);
    mmio_write(8'h08, 32'h10);
    mmio_write(8'h0C, 32'h20);
  endtask

  task automatic test_reset();
    logic [7:0]  offs [11];
    logic [31:0] exps [11];
    logic [31:0] d;
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h80};
    exps = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
             32'h0001_0000, 32'd0, 32'd0, 32'd0};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.act_ready !== 1'b1) $display("FAIL reset_act_ready got %b want 1", bus.act_ready); else passes++;
    checks++; if (bus.exec_valid !== 1'b0) $display("FAIL reset_exec_valid got %b want 0", bus.exec_valid); else passes++;
    checks++; if (bus.deny_pulse !== 1'b0) $display("FAIL reset_deny_pulse got %b want 0", bus.deny_pulse); else passes++;
    checks++; if (bus.exec_opcode !== 32'd0) $display("FAIL reset_exec_opcode got %h want 0", bus.exec_opcode); else passes++;
    for (int i = 0; i < 11; i++) begin
      mmio_read(offs[i], d);
      checks++; if (d !== exps[i]) $display("FAIL reset_reg_%h got %h want %h", offs[i], d, exps[i]); else passes++;
    end
    bus.sel = 1'b1; #1;
    checks++; if (bus.ack !== 1'b1) $display("FAIL ack_follows_sel got %b want 1", bus.ack); else passes++;
    bus.sel = 1'b0; #1;
    checks++; if (bus.ack !== 1'b0) $display("FAIL ack_idle got %b want 0", bus.ack); else passes++;
  endtask

  task automatic test_approve();
    logic [31:0] d;
    logic [2:0]  r;
    setup_policy();
    bus.exec_ready = 1'b0;
    drive_req(32'd2, 32'h18, 32'd5, nonce_seq); nonce_seq++;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.act_ready !== 1'b0) $display("FAIL approve_ready_low got %b want 0", bus.act_ready); else passes++;
    checks++; if (bus.exec_valid !== 1'b0) $display("FAIL approve_valid_c1 got %b want 0", bus.exec_valid); else passes++;
    bus.act_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.exec_valid !== 1'b0) $display("FAIL approve_valid_c2 got %b want 0", bus.exec_valid); else passes++;
    @(negedge clk);
    checks++; if (bus.exec_valid !== 1'b1) $display("FAIL approve_valid_c3 got %b want 1", bus.exec_valid); else passes++;
    checks++; if (bus.exec_opcode !== 32'd2) $display("FAIL approve_opcode got %h want 2", bus.exec_opcode); else passes++;
    checks++; if (bus.exec_target !== 32'h18) $display("FAIL approve_target got %h want 18", bus.exec_target); else passes++;
    checks++; if (bus.exec_arg0 !== 32'd5) $display("FAIL approve_arg0 got %h want 5", bus.exec_arg0); else passes++;
    checks++; if (bus.exec_arg1 !== 32'hA1) $display("FAIL approve_arg1 got %h want a1", bus.exec_arg1); else passes++;
    @(negedge clk);
    checks++; if (bus.exec_valid !== 1'b1) $display("FAIL approve_valid_held got %b want 1", bus.exec_valid); else passes++;
    bus.exec_ready = 1'b1;
    @(negedge clk);
    bus.exec_ready = 1'b0;
    checks++; if (bus.exec_valid !== 1'b0) $display("FAIL approve_valid_drop got %b want 0", bus.exec_valid); else passes++;
    exp_acc++;
    mmio_read(8'h14, d);
    checks++; if (d !== exp_acc) $display("FAIL approve_accept_cnt got %0d want %0d", d, exp_acc); else passes++;
    read_reason(r);
    checks++; if (r !== 3'd0) $display("FAIL approve_reason got %0d want 0", r); else passes++;
    @(negedge clk);
    checks++; if (bus.act_ready !== 1'b1) $display("FAIL approve_ready_back got %b want 1", bus.act_ready); else passes++;
  endtask

  task automatic test_opcode_deny();
    int nd, ne, fe;
    logic [31:0] d;
    logic [2:0]  r;
    do_req(32'd3, 32'h18, 32'd5, nonce_seq, 0, 8'h00, 32'd0, nd, ne, fe); nonce_seq++;
    exp_deny++;
    checks++; if (nd !== 1) $display("FAIL opdeny_pulses got %0d want 1", nd); else passes++;
    checks++; if (ne !== 0) $display("FAIL opdeny_exec got %0d want 0", ne); else passes++;
    mmio_read(8'h18, d);
    checks++; if (d !== exp_deny) $display("FAIL opdeny_deny_cnt got %0d want %0d", d, exp_deny); else passes++;
    read_reason(r);
    checks++; if (r !== 3'd2) $display("FAIL opdeny_reason got %0d want 2", r); else passes++;
  endtask

  task automatic test_priority();
    logic [31:0] ops [7];
    logic [31:0] tgts [7];
    logic [31:0] a0s [7];
    logic [2:0]  rs [7];
    int nd, ne, fe;
    logic [31:0] d;
    logic [2:0]  r;
    ops  = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'h22, 32'd3};
    tgts = '{32'h21, 32'h20, 32'h0F, 32'h10, 32'h10, 32'h18, 32'h21};
    a0s  = '{32'd5, 32'd5, 32'd5, 32'h101, 32'h100, 32'd5, 32'h200};
    rs   = '{3'd3, 3'd0, 3'd3, 3'd4, 3'd0, 3'd2, 3'd1};
    mmio_write(8'h10, 32'h100);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) mmio_write(8'h00, 32'd0);
      do_req(ops[i], tgts[i], a0s[i], nonce_seq, 0, 8'h00, 32'd0, nd, ne, fe); nonce_seq++;
      if (rs[i] == 3'd0) exp_acc++; else exp_deny++;
      read_reason(r);
      checks++; if (r !== rs[i]) $display("FAIL prio_reason_%0d got %0d want %0d", i, r, rs[i]); else passes++;
      checks++; if (ne !== ((rs[i] == 3'd0) ? 1 : 0)) $display("FAIL prio_exec_%0d got %0d", i, ne); else passes++;
      checks++; if (nd !== ((rs[i] == 3'd0) ? 0 : 1)) $display("FAIL prio_deny_%0d got %0d", i, nd); else passes++;
    end
    mmio_read(8'h14, d);
    checks++; if (d !== exp_acc) $display("FAIL prio_accept_cnt got %0d want %0d", d, exp_acc); else passes++;
    mmio_read(8'h18, d);
    checks++; if (d !== exp_deny) $display("FAIL prio_deny_cnt got %0d want %0d", d, exp_deny); else passes++;
    mmio_write(8'h00, 32'd1);
  endtask

  task automatic test_snapshot();
    int nd, ne, fe;
    logic [31:0] d;
    logic [2:0]  r;
    // Disable the gate one cycle into evaluation: the captured request still uses the enabled policy.
    do_req(32'd2, 32'h18, 32'd5, nonce_seq, 1, 8'h00, 32'd0, nd, ne, fe); nonce_seq++;
    exp_acc++;
    checks++; if (ne !== 1) $display("FAIL snap_exec got %0d want 1", ne); else passes++;
    checks++; if (fe !== 3) $display("FAIL snap_latency got %0d want 3", fe); else passes++;
    mmio_read(8'h00, d);
    checks++; if (d !== 32'd0) $display("FAIL snap_ctrl_written got %h want 0", d); else passes++;
    do_req(32'd2, 32'h18, 32'd5, nonce_seq, 0, 8'h00, 32'd0, nd, ne, fe); nonce_seq++;
    exp_deny++;
    read_reason(r);
    checks++; if (r !== 3'd1) $display("FAIL snap_next_reason got %0d want 1", r); else passes++;
    mmio_write(8'h00, 32'd1);
  endtask

  task automatic test_hold_valid();
    int ready_hi = 0;
    int nd = 0;
    int ne = 0;
    logic [31:0] d;
    drive_req(32'd3, 32'h18, 32'd5, nonce_seq); nonce_seq++;
    @(posedge clk);
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      if (bus.act_ready) ready_hi++;
      if (bus.deny_pulse) nd++;
      if (bus.exec_valid) ne++;
    end
    bus.act_valid = 1'b0;
    exp_deny++;
    checks++; if (ready_hi !== 0) $display("FAIL hold_ready_seen got %0d want 0", ready_hi); else passes++;
    checks++; if (nd !== 1) $display("FAIL hold_deny_pulses got %0d want 1", nd); else passes++;
    checks++; if (ne !== 0) $display("FAIL hold_exec got %0d want 0", ne); else passes++;
    @(negedge clk);
    checks++; if (bus.act_ready !== 1'b1) $display("FAIL hold_ready_back got %b want 1", bus.act_ready); else passes++;
    mmio_read(8'h18, d);
    checks++; if (d !== exp_deny) $display("FAIL hold_deny_cnt got %0d want %0d", d, exp_deny); else passes++;
  endtask

  task automatic test_clear();
    int nd, ne, fe;
    logic [31:0] d;
    logic [2:0]  r;
    mmio_write(8'h00, 32'd3);
    exp_acc = 0; exp_deny = 0;
    mmio_read(8'h14, d);
    checks++; if (d !== 32'd0) $display("FAIL clr_accept got %0d want 0", d); else passes++;
    mmio_read(8'h18, d);
    checks++; if (d !== 32'd0) $display("FAIL clr_deny got %0d want 0", d); else passes++;
    mmio_read(8'h00, d);
    checks++; if (d !== 32'd1) $display("FAIL clr_ctrl_read got %h want 1", d); else passes++;
    // Clear lands on the same edge as the denial increment.
    do_req(32'd3, 32'h18, 32'd5, nonce_seq, 2, 8'h00, 32'd3, nd, ne, fe); nonce_seq++;
    checks++; if (nd !== 1) $display("FAIL clr_race_pulse got %0d want 1", nd); else passes++;
    mmio_read(8'h18, d);
    checks++; if (d !== 32'd0) $display("FAIL clr_race_deny_cnt got %0d want 0", d); else passes++;
    read_reason(r);
    checks++; if (r !== 3'd2) $display("FAIL clr_race_reason got %0d want 2", r); else passes++;
  endtask

  task automatic test_reset_mid();
    int nd, ne, fe;
    int stuck = 0;
    logic [31:0] d;
    do_req(32'd2, 32'h18, 32'd5, nonce_seq, 0, 8'h00, 32'd0, nd, ne, fe); nonce_seq++;
    mmio_read(8'h14, d);
    checks++; if (d !== 32'd1) $display("FAIL rstmid_pre_accept got %0d want 1", d); else passes++;
    bus.exec_ready = 1'b0;
    drive_req(32'd2, 32'h18, 32'd5, nonce_seq); nonce_seq++;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) bus.act_valid = 1'b0;
      if (i >= 3 && bus.exec_valid) stuck++;
    end
    checks++; if (stuck !== 8) $display("FAIL rstmid_valid_held got %0d want 8", stuck); else passes++;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.exec_valid !== 1'b0) $display("FAIL rstmid_exec_valid got %b want 0", bus.exec_valid); else passes++;
    checks++; if (bus.act_ready !== 1'b1) $display("FAIL rstmid_act_ready got %b want 1", bus.act_ready); else passes++;
    mmio_read(8'h14, d);
    checks++; if (d !== 32'd0) $display("FAIL rstmid_accept got %0d want 0", d); else passes++;
    mmio_read(8'h00, d);
    checks++; if (d !== 32'd0) $display("FAIL rstmid_ctrl got %h want 0", d); else passes++;
    rst = 1'b0;
    @(negedge clk);
    mmio_read(8'h1C, d);
    checks++; if (d !== 32'h0001_0000) $display("FAIL rstmid_status got %h want 00010000", d); else passes++;
  endtask

  task automatic test_nonce();
    int nd, ne, fe;
    logic [31:0] d;
    logic [2:0]  r;
    setup_policy();
`ifdef BOREAL_GATE_NONCE_EN
    do_req(32'd2, 32'h18, 32'd5, 32'd0, 0, 8'h00, 32'd0, nd, ne, fe);
    read_reason(r);
    checks++; if (r !== 3'd5) $display("FAIL nonce_zero_reason got %0d want 5", r); else passes++;
    do_req(32'd2, 32'h18, 32'd5, 32'd5, 0, 8'h00, 32'd0, nd, ne, fe);
    checks++; if (ne !== 1) $display("FAIL nonce5_exec got %0d want 1", ne); else passes++;
    do_req(32'd2, 32'h18, 32'd5, 32'd5, 0, 8'h00, 32'd0, nd, ne, fe);
    read_reason(r);
    checks++; if (r !== 3'd5) $display("FAIL nonce_replay_reason got %0d want 5", r); else passes++;
    checks++; if (ne !== 0) $display("FAIL nonce_replay_exec got %0d want 0", ne); else passes++;
    do_req(32'd2, 32'h18, 32'd5, 32'd6, 0, 8'h00, 32'd0, nd, ne, fe);
    read_reason(r);
    checks++; if (r !== 3'd0) $display("FAIL nonce6_reason got %0d want 0", r); else passes++;
    mmio_read(8'h20, d);
    checks++; if (d !== 32'd6) $display("FAIL nonce_last got %0d want 6", d); else passes++;
`else
    do_req(32'd2, 32'h18, 32'd5, 32'd0, 0, 8'h00, 32'd0, nd, ne, fe);
    checks++; if (ne !== 1) $display("FAIL nonce_ignored_1 got %0d want 1", ne); else passes++;
    do_req(32'd2, 32'h18, 32'd5, 32'd0, 0, 8'h00, 32'd0, nd, ne, fe);
    read_reason(r);
    checks++; if (r !== 3'd0) $display("FAIL nonce_ignored_reason got %0d want 0", r); else passes++;
    mmio_read(8'h20, d);
    checks++; if (d !== 32'd0) $display("FAIL nonce_reg_absent got %h want 0", d); else passes++;
`endif
  endtask

  initial begin
    bus.sel = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.act_valid = 1'b0; bus.act_opcode = '0; bus.act_target = '0; bus.act_arg0 = '0;
    bus.act_arg1 = '0; bus.act_context_hash = '0; bus.act_policy_hash = '0;
    bus.act_bounds = '0; bus.act_nonce = '0; bus.exec_ready = 1'b0;
    rst = 1'b1;
    test_reset();
    test_approve();
    test_opcode_deny();
    test_priority();
    test_snapshot();
    test_hold_valid();
    test_clear();
    test_reset_mid();
    test_nonce();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passes, checks);
    $fatal(1);
  end

endmodule
